// File: rtl/cache_refill_fsm.sv
// Critical-word-first line refill controller: fetches the four words of a missed
// 16-byte line from RAM, forwards the critical word, then writes the whole line.
module cache_refill_fsm #(
    parameter int ADDRESS_WIDTH       = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int CACHE_DATA_WIDTH    = 153,
    parameter int CACHE_ADDRESS_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_req,
    input  logic [ADDRESS_WIDTH-1:0]       miss_addr,
    output logic                           stall,
    output logic                           mem_req,
    output logic [ADDRESS_WIDTH-1:0]       mem_addr,
    input  logic                           mem_ack,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           crit_valid,
    output logic [DATA_WIDTH-1:0]          crit_data,
    output logic                           line_we,
    output logic [CACHE_ADDRESS_WIDTH-1:0] line_set,
    output logic [CACHE_DATA_WIDTH-1:0]    line_data
);

    typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

    state_t                         state;
    logic [1:0]                     k;
    logic [ADDRESS_WIDTH-1:0]       addr;
    logic [3:0][DATA_WIDTH-1:0]     line_buf;
    logic [3:0][DATA_WIDTH-1:0]     buf_next;
    logic [1:0]                     off;
    logic [1:0]                     off_next;

    assign off      = addr[3:2] + k;
    assign off_next = off + 2'd1;

    assign stall = !rst && ((state != IDLE) || miss_req);

    // Buffer including the word arriving this cycle, so the final word can go
    // straight into the registered line write without an extra cycle.
    always_comb begin
        buf_next = line_buf;
        if (state == FETCH && mem_ack) begin
            buf_next[off] = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 2'd0;
            addr       <= '0;
            line_buf   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            line_we    <= 1'b0;
            line_set   <= '0;
            line_data  <= '0;
        end else begin
            crit_valid <= 1'b0;
            line_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        addr     <= miss_addr;
                        k        <= 2'd0;
                        mem_req  <= 1'b1;
                        mem_addr <= {miss_addr[ADDRESS_WIDTH-1:4], miss_addr[3:2], 2'b00};
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        line_buf <= buf_next;
                        k        <= k + 2'd1;
                        if (k == 2'd0) begin
                            crit_valid <= 1'b1;
                            crit_data  <= mem_rdata;
                        end
                        if (k == 2'd3) begin
                            mem_req   <= 1'b0;
                            line_we   <= 1'b1;
                            line_set  <= addr[7:4];
                            line_data <= {1'b1, addr[ADDRESS_WIDTH-1:8], buf_next};
                            state     <= FILL;
                        end else begin
                            mem_addr <= {addr[ADDRESS_WIDTH-1:4], off_next, 2'b00};
                        end
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_fsm.sv
// Directed bench for cache_refill_fsm; the RAM model returns {8'hD0, addr[23:0]}.
module tb_cache_refill_fsm;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_we;
    logic [3:0]   line_set;
    logic [152:0] line_data;

    int errors = 0;
    int checks = 0;

    cache_refill_fsm dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .crit_valid(crit_valid), .crit_data(crit_data),
        .line_we(line_we), .line_set(line_set), .line_data(line_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {8'hD0, a[23:0]};
    endfunction

    // One cycle: drive inputs after the falling edge, settle, then the caller checks.
    task automatic apply_stimulus(input logic miss, input logic [31:0] maddr, input logic ack);
        @(negedge clk);
        miss_req  = miss;
        miss_addr = maddr;
        mem_ack   = ack;
        mem_rdata = ack ? ram_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [152:0] observed, input logic [152:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [31:0] exp_addr [4];

    initial begin
        // Reset asserted asynchronously between clock edges
        #1 rst = 1'b1;
        #2;
        check_output("rst_stall", 153'(stall), 153'(1'b0));
        check_output("rst_mem_req", 153'(mem_req), 153'(1'b0));
        check_output("rst_line_data", line_data, 153'(0));
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("idle_stall", 153'(stall), 153'(1'b0));

        // Critical word first with wrap, zero-wait RAM
        exp_addr = '{32'h10024, 32'h10028, 32'h1002C, 32'h10020};
        apply_stimulus(1'b1, 32'h0001_0026, 1'b0);
        check_output("t1_c0_stall", 153'(stall), 153'(1'b1));
        check_output("t1_c0_mem_req", 153'(mem_req), 153'(1'b0));
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output("t1_mem_req", 153'(mem_req), 153'(1'b1));
            check_output("t1_mem_addr", 153'(mem_addr), 153'(exp_addr[c]));
            check_output("t1_crit_valid", 153'(crit_valid), 153'(c == 1));
        end
        check_output("t1_crit_data", 153'(crit_data), 153'(32'hD001_0024));
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t1_c5_line_we", 153'(line_we), 153'(1'b1));
        check_output("t1_c5_line_set", 153'(line_set), 153'(4'd2));
        check_output("t1_c5_line_data", line_data,
                     {1'b1, 24'h000100, 32'hD001_002C, 32'hD001_0028, 32'hD001_0024, 32'hD001_0020});
        check_output("t1_c5_mem_req", 153'(mem_req), 153'(1'b0));
        check_output("t1_c5_stall", 153'(stall), 153'(1'b1));
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t1_c6_stall", 153'(stall), 153'(1'b0));
        check_output("t1_c6_line_we", 153'(line_we), 153'(1'b0));

        // Two wait states per word: ack on every third cycle
        exp_addr = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
        apply_stimulus(1'b1, 32'h0000_1238, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            apply_stimulus(1'b0, 32'h0, (c % 3) == 0);
            check_output("t2_mem_addr", 153'(mem_addr), 153'(exp_addr[(c - 1) / 3]));
            check_output("t2_stall", 153'(stall), 153'(1'b1));
            check_output("t2_crit_valid", 153'(crit_valid), 153'(c == 4));
        end
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t2_c13_line_we", 153'(line_we), 153'(1'b1));
        check_output("t2_c13_line_set", 153'(line_set), 153'(4'd3));
        check_output("t2_c13_line_data", line_data,
                     {1'b1, 24'h000012, 32'hD000_123C, 32'hD000_1238, 32'hD000_1234, 32'hD000_1230});
        check_output("t2_c13_stall", 153'(stall), 153'(1'b1));
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t2_c14_stall", 153'(stall), 153'(1'b0));

        // Miss requests during a refill and stray acks in idle are ignored
        apply_stimulus(1'b1, 32'h0000_0044, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_c1_mem_addr", 153'(mem_addr), 153'(32'h44));
        apply_stimulus(1'b1, 32'h0002_0010, 1'b1);
        check_output("t3_c2_mem_addr", 153'(mem_addr), 153'(32'h48));
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_c3_mem_addr", 153'(mem_addr), 153'(32'h4C));
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_c4_mem_addr", 153'(mem_addr), 153'(32'h40));
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t3_c5_line_we", 153'(line_we), 153'(1'b1));
        check_output("t3_c5_line_set", 153'(line_set), 153'(4'd4));
        check_output("t3_c5_line_data", line_data,
                     {1'b1, 24'h000000, 32'hD000_004C, 32'hD000_0048, 32'hD000_0044, 32'hD000_0040});
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_stray_stall", 153'(stall), 153'(1'b0));
        check_output("t3_stray_mem_req", 153'(mem_req), 153'(1'b0));
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_stray_crit_valid", 153'(crit_valid), 153'(1'b0));
        check_output("t3_stray_mem_req2", 153'(mem_req), 153'(1'b0));
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t3_stray_line_we", 153'(line_we), 153'(1'b0));
        check_output("t3_stray_stall2", 153'(stall), 153'(1'b0));

        // Reset after two acks discards the partial line
        apply_stimulus(1'b1, 32'h0000_0050, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t4_pre_mem_req", 153'(mem_req), 153'(1'b1));
        rst = 1'b1;
        #1;
        check_output("t4_rst_stall", 153'(stall), 153'(1'b0));
        check_output("t4_rst_mem_req", 153'(mem_req), 153'(1'b0));
        check_output("t4_rst_mem_addr", 153'(mem_addr), 153'(32'h0));
        check_output("t4_rst_crit_valid", 153'(crit_valid), 153'(1'b0));
        check_output("t4_rst_crit_data", 153'(crit_data), 153'(32'h0));
        check_output("t4_rst_line_we", 153'(line_we), 153'(1'b0));
        check_output("t4_rst_line_set", 153'(line_set), 153'(4'd0));
        check_output("t4_rst_line_data", line_data, 153'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output("t4_no_line_we", 153'(line_we), 153'(1'b0));
            check_output("t4_idle_stall", 153'(stall), 153'(1'b0));
        end
        exp_addr = '{32'h6C, 32'h60, 32'h64, 32'h68};
        apply_stimulus(1'b1, 32'h0000_006C, 1'b0);
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output("t4_mem_addr", 153'(mem_addr), 153'(exp_addr[c]));
        end
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t4_line_we", 153'(line_we), 153'(1'b1));
        check_output("t4_line_set", 153'(line_set), 153'(4'd6));
        check_output("t4_line_data", line_data,
                     {1'b1, 24'h000000, 32'hD000_006C, 32'hD000_0068, 32'hD000_0064, 32'hD000_0060});

        // Back-to-back misses: request held through FILL is taken the cycle after
        exp_addr = '{32'h94, 32'h98, 32'h9C, 32'h90};
        apply_stimulus(1'b1, 32'h0000_0080, 1'b0);
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
        end
        apply_stimulus(1'b1, 32'h0000_0094, 1'b0);
        check_output("t5_c5_line_we", 153'(line_we), 153'(1'b1));
        check_output("t5_c5_line_set", 153'(line_set), 153'(4'd8));
        check_output("t5_c5_stall", 153'(stall), 153'(1'b1));
        apply_stimulus(1'b1, 32'h0000_0094, 1'b0);
        check_output("t5_c6_stall", 153'(stall), 153'(1'b1));
        check_output("t5_c6_mem_req", 153'(mem_req), 153'(1'b0));
        check_output("t5_c6_line_we", 153'(line_we), 153'(1'b0));
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output("t5_mem_req", 153'(mem_req), 153'(1'b1));
            check_output("t5_mem_addr", 153'(mem_addr), 153'(exp_addr[c]));
        end
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t5_c11_line_we", 153'(line_we), 153'(1'b1));
        check_output("t5_c11_line_set", 153'(line_set), 153'(4'd9));
        check_output("t5_c11_line_data", line_data,
                     {1'b1, 24'h000000, 32'hD000_009C, 32'hD000_0098, 32'hD000_0094, 32'hD000_0090});
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t5_c12_stall", 153'(stall), 153'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_fsm.md
# cache_refill_fsm

Multi-cycle line-refill controller between the data cache and the backing byte-addressed RAM. When the cache reports a read miss, the block stalls the CPU and fetches the four words of the missing 16-byte line over a request/acknowledge handshake, critical word first. It forwards the critical word to the load path as soon as it arrives, then writes the assembled 153-bit line (valid, tag, four words) into the cache set in one cycle.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width; A[31:8] is the tag, A[7:4] the set, A[3:2] the block offset, A[1:0] the byte offset.
- DATA_WIDTH, 32, word width.
- CACHE_DATA_WIDTH, 153, line width: 1 valid bit + 24 tag bits + 128 data bits.
- CACHE_ADDRESS_WIDTH, 4, set index width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  1  read miss detected by the cache this cycle.
- miss_addr  in  ADDRESS_WIDTH  byte address of the missing load.
- stall  out  1  holds the CPU pipeline.
- mem_req  out  1  word read request to RAM.
- mem_addr  out  ADDRESS_WIDTH  word-aligned address of the request.
- mem_ack  in  1  RAM has returned mem_rdata for the current request this cycle.
- mem_rdata  in  DATA_WIDTH  returned word, valid only when mem_ack is high.
- crit_valid  out  1  one-cycle pulse: the critical word is on crit_data.
- crit_data  out  DATA_WIDTH  critical word; the raw word, with no byte selection applied.
- line_we  out  1  one-cycle cache line write strobe.
- line_set  out  CACHE_ADDRESS_WIDTH  set index for the line write.
- line_data  out  CACHE_DATA_WIDTH  {1'b1, tag[23:0], w3, w2, w1, w0}, with w0 in bits [31:0].

## Operation
- States: IDLE, FETCH, FILL.
- **IDLE**
  - miss_req=1: latch miss_addr and set word counter k=0. Next state is FETCH.
  - mem_ack is ignored in IDLE.
- **FETCH**
  - mem_req=1.
  - mem_addr = {addr[31:4], off, 2'b00}, where off = addr[3:2] + k (2-bit, wraps 3→0). Byte offset bits are always zero.
  - On mem_ack: store mem_rdata in line buffer slot off, then k++.
  - On ack with k==0: crit_valid=1 and crit_data=mem_rdata, both registered, so they appear the following cycle.
  - On ack with k==3: next state is FILL.
- **FILL**
  - line_we=1, line_set=addr[7:4], line_data={1'b1, addr[31:8], buf3, buf2, buf1, buf0}.
  - Next state is IDLE.
- stall = (state != IDLE) || (state == IDLE && miss_req). This is combinational, so the CPU stalls in the miss cycle itself.
- Busy handling: miss_req and miss_addr changes are ignored outside IDLE; the latched addr is used for the whole refill.
- Writes bypass this block; the cache handles stores write-through. No writeback is ever issued.
- Reset (asynchronous, any state):
  - State returns to IDLE; k=0; addr and line buffer are cleared to 0.
  - All outputs go to 0: stall, mem_req, mem_addr, crit_valid, crit_data, line_we, line_set, line_data.
  - A partial line is discarded; no line_we is ever issued for it.

## Timing
- mem_req stays high with mem_addr stable until the cycle mem_ack=1.
- mem_ack may arrive in the same cycle mem_req rises, giving zero wait states.
- After an ack with k<3, the next cycle keeps mem_req=1 with the next word address; there is no bubble between words.
- mem_req is 0 in IDLE and FILL.
- Zero-wait RAM, miss accepted in cycle 0:
  - FETCH in cycles 1–4; crit_valid in cycle 2.
  - FILL with line_we in cycle 5; stall high in cycles 0–5.
  - Back in IDLE at cycle 6 with stall=0.
- With W wait cycles per word: FETCH occupies 4·(W+1) cycles and FILL follows at cycle 4·(W+1)+1.
- line_we and crit_valid are exactly one cycle wide.
- A miss_req present in the FILL cycle is not accepted. It is accepted in the following IDLE cycle if still asserted.

## Test plan
- **Reset:** assert rst mid-cycle → all outputs read 0 immediately (asynchronously); after release, state is IDLE and stall=0 with miss_req=0.
- **Critical-word-first with wrap, zero-wait RAM:** miss_addr=0x00010026 with RAM words 0x10020=A0, 0x10024=A4, 0x10028=A8, 0x1002C=AC →
  - mem_addr sequence is 0x10024, 0x10028, 0x1002C, 0x10020 in cycles 1–4.
  - crit_data=A4 in cycle 2.
  - Cycle 5: line_we=1, line_set=2, line_data={1, 0x000100, AC, A8, A4, A0}.
- **Wait states:** ack every 3rd cycle (W=2) → mem_addr is held for 3 cycles per word; FILL at cycle 13; stall high in cycles 0–13.
- **Busy filtering:** miss_req=1 with miss_addr=0x00020010 during FETCH → no restart, line_set remains the original set; a stray mem_ack in IDLE → no state change and no crit_valid.
- **Reset mid-refill:** rst pulsed after 2 acks → no line_we ever issued; a new miss to offset 3 then starts at word address …C and completes normally.
- **Back-to-back misses:** miss_req held high through FILL with a new address at cycle 5 → second refill accepted in cycle 6 and its line_we occurs at cycle 11.
